// File: rtl/smiley_collision_detect_pkg.sv
// Shared types and default constants for the smiley collision detector.
package smiley_collision_detect_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam int COOLDOWN_FRAMES_DEF = 4;
  localparam int HIT_CNT_W_DEF       = 8;

endpackage

// File: rtl/smiley_collision_detect_frame_flag_latch.sv
// Sticky per-frame overlap flag. A frame boundary reloads the flag with the
// overlap seen in that same clk, so an overlap on the first clk of a frame
// is kept for the next evaluation.
module frame_flag_latch (
  input  logic clk,
  input  logic reset,
  input  logic sof,
  input  logic ov,
  output logic flag
);

  // Set on overlap, reloaded with the current overlap at each frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      flag <= 1'b0;
    end else if (sof) begin
      flag <= ov;
    end else if (ov) begin
      flag <= 1'b1;
    end
  end

endmodule

// File: rtl/smiley_collision_detect.sv
// Smiley collision detector: latches border/box overlaps per frame and, at
// the following frame boundary, reports at most one hit, then ignores hits
// for a number of frames.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | after reset, waiting for the first frame boundary
// ARMED    | evaluating flags at every frame boundary
// COOLDOWN | counting frames after a reported hit, flags ignored
module smiley_collision_detect
  import smiley_collision_detect_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
  parameter int HIT_CNT_W       = HIT_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 drawReq_smiley,
  input  logic                 drawReq_border,
  input  logic                 drawReq_box,
  output logic                 collision,
  output logic                 toggleY,
  output logic [HIT_CNT_W-1:0] hitCount,
  output logic                 armed
);

  localparam logic [3:0]           CD_LOAD = 4'(COOLDOWN_FRAMES);
  localparam logic [HIT_CNT_W-1:0] HIT_MAX = '1;

  logic   border_ov;
  logic   box_ov;
  logic   border_f;
  logic   box_f;
  state_t state;
  logic   [3:0] cd_cnt;

  assign border_ov = drawReq_smiley & drawReq_border;
  assign box_ov    = drawReq_smiley & drawReq_box;

  frame_flag_latch u_border_flag (
    .clk   (clk),
    .reset (reset),
    .sof   (startOfFrame),
    .ov    (border_ov),
    .flag  (border_f)
  );

  frame_flag_latch u_box_flag (
    .clk   (clk),
    .reset (reset),
    .sof   (startOfFrame),
    .ov    (box_ov),
    .flag  (box_f)
  );

  // Hit/cooldown sequencer with registered pulse outputs and hit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cd_cnt    <= 4'd0;
      collision <= 1'b0;
      toggleY   <= 1'b0;
      hitCount  <= '0;
      armed     <= 1'b0;
    end else begin
      collision <= 1'b0;
      toggleY   <= 1'b0;
      case (state)
        IDLE: begin
          if (startOfFrame) begin
            state <= ARMED;
            armed <= 1'b1;
          end
        end
        ARMED: begin
          if (startOfFrame && (border_f || box_f)) begin
            // border has priority when both overlapped in the frame
            collision <= border_f;
            toggleY   <= ~border_f;
            if (hitCount != HIT_MAX) begin
              hitCount <= hitCount + HIT_CNT_W'(1);
            end
            cd_cnt <= CD_LOAD;
            state  <= COOLDOWN;
            armed  <= 1'b0;
          end
        end
        COOLDOWN: begin
          if (startOfFrame) begin
            cd_cnt <= cd_cnt - 4'd1;
            if (cd_cnt <= 4'd1) begin
              state <= ARMED;
              armed <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          cd_cnt <= 4'd0;
          armed  <= 1'b0;
        end
      endcase
    end
  end

endmodule
